// File: rtl/flash_audio_reader_pkg.sv
// Shared types and constants for the flash audio playback path and the
// keyboard control FSM that drives it.
package flash_audio_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_DATA,
    S_EMIT,
    S_FINISH
  } reader_state_t;

  localparam int unsigned       FLASH_ADDR_W  = 23;
  localparam logic [22:0]       MAX_WORD_ADDR = 23'h7FFFF;

  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_BWD = 1'b1;

  // Keyboard characters the control FSM reacts to (ASCII).
  localparam logic [7:0] KEY_UPPER_B = 8'h42;  // backward
  localparam logic [7:0] KEY_UPPER_D = 8'h44;  // pause
  localparam logic [7:0] KEY_UPPER_E = 8'h45;  // play
  localparam logic [7:0] KEY_UPPER_F = 8'h46;  // forward
  localparam logic [7:0] KEY_UPPER_R = 8'h52;  // restart
  localparam logic [7:0] KEY_LOWER_B = 8'h62;
  localparam logic [7:0] KEY_LOWER_D = 8'h64;
  localparam logic [7:0] KEY_LOWER_E = 8'h65;
  localparam logic [7:0] KEY_LOWER_F = 8'h66;
  localparam logic [7:0] KEY_LOWER_R = 8'h72;

endpackage

// File: rtl/flash_audio_reader_if.sv
// Avalon-MM read-only master/slave bundle between the reader and flash.
interface flash_audio_reader_if #(
  parameter int unsigned ADDR_W = 23,
  parameter int unsigned DATA_W = 32
);
  logic              flash_mem_read;
  logic [ADDR_W-1:0] flash_mem_address;
  logic [3:0]        flash_mem_byteenable;
  logic              flash_mem_waitrequest;
  logic [DATA_W-1:0] flash_mem_readdata;
  logic              flash_mem_readdatavalid;

  modport master (
    output flash_mem_read,
    output flash_mem_address,
    output flash_mem_byteenable,
    input  flash_mem_waitrequest,
    input  flash_mem_readdata,
    input  flash_mem_readdatavalid
  );

  modport slave (
    input  flash_mem_read,
    input  flash_mem_address,
    input  flash_mem_byteenable,
    output flash_mem_waitrequest,
    output flash_mem_readdata,
    output flash_mem_readdatavalid
  );
endinterface

// File: rtl/flash_audio_reader_addr_counter.sv
// Up/down flash word-address counter wrapping over [0, MAX_WORD_ADDR].
module flash_word_addr_counter
  import flash_audio_pkg::*;
#(
  parameter int unsigned       ADDR_W        = 23,
  parameter logic [ADDR_W-1:0] MAX_WORD_ADDR = flash_audio_pkg::MAX_WORD_ADDR
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              step,
  input  logic              dir,
  output logic [ADDR_W-1:0] addr
);

  // Load has priority over a step; steps wrap at both ends of the image.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr <= '0;
    end else if (load) begin
      addr <= load_val;
    end else if (step) begin
      if (dir == DIR_BWD) begin
        addr <= (addr == '0) ? MAX_WORD_ADDR : addr - ADDR_W'(1);
      end else begin
        addr <= (addr == MAX_WORD_ADDR) ? '0 : addr + ADDR_W'(1);
      end
    end
  end

endmodule

// File: rtl/flash_audio_reader.sv
// Flash playback engine: fetches 32-bit words over Avalon-MM and emits one
// 16-bit sample per sample_tick, pulsing read_finish after each sample.
module flash_audio_reader
  import flash_audio_pkg::*;
#(
  parameter int unsigned       ADDR_W        = 23,
  parameter logic [ADDR_W-1:0] MAX_WORD_ADDR = flash_audio_pkg::MAX_WORD_ADDR,
  parameter int unsigned       SAMPLE_W      = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                sample_tick,
  input  logic                start_read,
  input  logic                dir,
  input  logic                restart,
  output logic                read_finish,
  output logic [SAMPLE_W-1:0] audio_data,
  flash_audio_reader_if.master flash
);

  localparam int unsigned WORD_W = 2 * SAMPLE_W;

  reader_state_t     state;
  logic [WORD_W-1:0] word_buf;
  logic              word_valid;
  logic              half_sel;
  logic              word_dir;
  logic              play_dir;
  logic              mem_read;
  logic [ADDR_W-1:0] word_addr;
  logic [ADDR_W-1:0] load_val;
  logic              play_go;
  logic              ctr_load;
  logic              ctr_step;
  logic              last_half;

  assign play_go   = (state == S_IDLE) && sample_tick && start_read;
  assign ctr_load  = play_go && restart;
  assign load_val  = dir ? MAX_WORD_ADDR : '0;
  // The second half of a word is the one opposite to its starting half.
  assign last_half = (half_sel != word_dir);
  assign ctr_step  = (state == S_EMIT) && last_half;

  assign flash.flash_mem_read       = mem_read;
  assign flash.flash_mem_address    = word_addr;
  assign flash.flash_mem_byteenable = 4'b1111;

  flash_word_addr_counter #(
    .ADDR_W       (ADDR_W),
    .MAX_WORD_ADDR(MAX_WORD_ADDR)
  ) u_addr_ctr (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (ctr_load),
    .load_val(load_val),
    .step    (ctr_step),
    .dir     (word_dir),
    .addr    (word_addr)
  );

  // Playback FSM with registered read request, sample output and handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      read_finish <= 1'b0;
      audio_data  <= '0;
      mem_read    <= 1'b0;
      word_buf    <= '0;
      word_valid  <= 1'b0;
      half_sel    <= 1'b0;
      word_dir    <= DIR_FWD;
      play_dir    <= DIR_FWD;
    end else begin
      read_finish <= 1'b0;
      case (state)
        S_IDLE: begin
          if (play_go) begin
            // dir is captured here so a later change cannot affect this fetch.
            play_dir <= dir;
            if (restart || !word_valid || (dir != word_dir)) begin
              word_valid <= 1'b0;
              mem_read   <= 1'b1;
              state      <= S_FETCH;
            end else begin
              state <= S_EMIT;
            end
          end
        end
        S_FETCH: begin
          if (!flash.flash_mem_waitrequest) begin
            mem_read <= 1'b0;
            state    <= S_WAIT_DATA;
          end
        end
        S_WAIT_DATA: begin
          if (flash.flash_mem_readdatavalid) begin
            word_buf   <= flash.flash_mem_readdata;
            word_valid <= 1'b1;
            word_dir   <= play_dir;
            half_sel   <= play_dir;
            state      <= S_EMIT;
          end
        end
        S_EMIT: begin
          audio_data  <= half_sel ? word_buf[WORD_W-1:SAMPLE_W] : word_buf[SAMPLE_W-1:0];
          half_sel    <= ~half_sel;
          read_finish <= 1'b1;
          if (last_half) begin
            word_valid <= 1'b0;
          end
          state <= S_FINISH;
        end
        S_FINISH: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
